// File: rtl/wb_regfile_if.sv
// Purpose: bundles the writeback triple and both decode read ports of wb_regfile.
// Latency: n/a (wires only); rdata1/rdata2 are combinational in the slave.
// Backpressure: none; the writeback path and the read ports never stall.
//
// Signals:
//   wb_wd, wb_wreg, wb_wdata   writeback destination index, enable, data
//   re1, raddr1 -> rdata1      read port 1 enable, index, data
//   re2, raddr2 -> rdata2      read port 2 enable, index, data
// Modports: master drives writeback + read requests, slave is the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;

  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;

  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  modport master (
    output wb_wd, wb_wreg, wb_wdata,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/wb_regfile.sv
// Purpose: architectural integer register file (x0 hardwired to zero) at the end of writeback.
// Latency: write commits at the next rising edge; both reads are combinational (0 cycles).
// Backpressure: none; every writeback is accepted, bubbles arrive as wb_wreg=0.
//
// Ports:
//   clk   core clock, all state updates on the rising edge
//   rst   synchronous active-high reset: clears every entry, drops the
//         write of that cycle and forces both read ports to zero
//   rf    wb_regfile_if.slave: writeback triple in, two read ports out
// Build option: define WB_RF_BYPASS_EN to forward a same-cycle writeback to a
// matching read port; without it a write is visible one cycle later.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Entry 0 is never stored; reads of index 0 are forced to zero below.
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  // A write to x0 is dropped here so it can neither be stored nor bypassed.
  logic wr_en;
  assign wr_en = rf.wb_wreg && (rf.wb_wd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rf.wb_wd] <= rf.wb_wdata;
    end
  end

  logic hit1;
  logic hit2;

`ifdef WB_RF_BYPASS_EN
  // Forward the value being committed this cycle so decode does not see stale data.
  assign hit1 = wr_en && rf.re1 && (rf.wb_wd == rf.raddr1);
  assign hit2 = wr_en && rf.re2 && (rf.wb_wd == rf.raddr2);
`else
  // No forwarding: the pipeline control resolves the write-to-read hazard.
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Priority: reset, disabled port, x0, bypass, array.
  always_comb begin
    rd1 = '0;
    if (rst || !rf.re1 || (rf.raddr1 == '0)) begin
      rd1 = '0;
    end else if (hit1) begin
      rd1 = rf.wb_wdata;
    end else begin
      rd1 = regs[rf.raddr1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (rst || !rf.re2 || (rf.raddr2 == '0)) begin
      rd2 = '0;
    end else if (hit2) begin
      rd2 = rf.wb_wdata;
    end else begin
      rd2 = regs[rf.raddr2];
    end
  end

  assign rf.rdata1 = rd1;
  assign rf.rdata2 = rd2;

endmodule

// File: tb/tb_wb_regfile.sv
// Purpose: self-checking bench for wb_regfile (directed vector table + random phase).
// Latency: one vector per cycle; outputs compared at the falling edge of that cycle.
// Backpressure: none; the bench drives one writeback/read set per cycle.
module tb_wb_regfile;

`ifdef WB_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) rf ();

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    int          idx;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  logic [31:0] mdl [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic wreg, input logic [4:0] wd,
                              input logic [31:0] wdata, input logic re1, input logic [4:0] ra1,
                              input logic re2, input logic [4:0] ra2,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.rst = r;   v.wreg = wreg; v.wd = wd;   v.wdata = wdata;
    v.re1 = re1; v.ra1 = ra1;   v.re2 = re2; v.ra2 = ra2;
    v.e1 = e1;   v.e2 = e2;
    return v;
  endfunction

  task automatic check_eq(input string name, input int idx, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the rising edge, queue its expectation,
  // then compare at the falling edge before the next commit edge.
  task automatic apply(input vec_t v, input int idx);
    sb_t e;
    sb_t got;
    @(posedge clk);
    #1;
    rst         = v.rst;
    rf.wb_wreg  = v.wreg;
    rf.wb_wd    = v.wd;
    rf.wb_wdata = v.wdata;
    rf.re1      = v.re1;
    rf.raddr1   = v.ra1;
    rf.re2      = v.re2;
    rf.raddr2   = v.ra2;
    e.e1 = v.e1; e.e2 = v.e2; e.idx = idx;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard [vec %0d]: queue empty", idx);
    end else begin
      got = sb.pop_front();
      check_eq("rdata1", got.idx, rf.rdata1, got.e1);
      check_eq("rdata2", got.idx, rf.rdata2, got.e2);
    end
  endtask

  // Reference read for the random phase, computed from the bench's own model.
  function automatic logic [31:0] model_rd(input vec_t v, input logic re, input logic [4:0] ra);
    if (v.rst || !re || ra == 5'd0) return 32'h0;
    if (BYP && v.wreg && v.wd != 5'd0 && v.wd == ra) return v.wdata;
    return mdl[ra];
  endfunction

  initial begin
    rst = 1'b1;
    rf.wb_wreg = 1'b0; rf.wb_wd = '0; rf.wb_wdata = '0;
    rf.re1 = 1'b0; rf.raddr1 = '0; rf.re2 = 1'b0; rf.raddr2 = '0;

    //                 rst wreg wd     wdata         re1 ra1    re2 ra2    exp1 / exp2
    // reset held two cycles with a pending write to x5
    tbl.push_back(mk(1, 1, 5'd5,  32'hDEADBEEF, 1, 5'd5,  1, 5'd5,  32'h0, 32'h0));
    tbl.push_back(mk(1, 1, 5'd5,  32'hDEADBEEF, 1, 5'd5,  1, 5'd5,  32'h0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd5,  1, 5'd0,  32'h0, 32'h0));
    // basic write/read
    tbl.push_back(mk(0, 1, 5'd7,  32'h12345678, 1, 5'd1,  1, 5'd2,  32'h0, 32'h0));
    tbl.push_back(mk(0, 1, 5'd31, 32'hA5A5A5A5, 1, 5'd7,  1, 5'd2,  32'h12345678, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd7,  1, 5'd31, 32'h12345678, 32'hA5A5A5A5));
    // x0 protection
    tbl.push_back(mk(0, 1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  1, 5'd0,  32'h0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd0,  1, 5'd0,  32'h0, 32'h0));
    // read enables
    tbl.push_back(mk(0, 1, 5'd3,  32'h55,       1, 5'd31, 1, 5'd7,  32'hA5A5A5A5, 32'h12345678));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        0, 5'd3,  1, 5'd3,  32'h0,  32'h55));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd3,  0, 5'd3,  32'h55, 32'h0));
    // wreg=0 writes nothing (and never bypasses)
    tbl.push_back(mk(0, 0, 5'd3,  32'hFFFFFFFF, 1, 5'd3,  1, 5'd3,  32'h55, 32'h55));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd3,  1, 5'd0,  32'h55, 32'h0));
    // same-cycle hazard on x9
    tbl.push_back(mk(0, 1, 5'd9,  32'h11,       1, 5'd3,  1, 5'd3,  32'h55, 32'h55));
    tbl.push_back(mk(0, 1, 5'd9,  32'h22,       1, 5'd9,  1, 5'd9,
                     BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  1, 5'd9,  32'h22, 32'h22));
    // back-to-back writes to the same index
    tbl.push_back(mk(0, 1, 5'd9,  32'h33,       1, 5'd9,  1, 5'd3,  BYP ? 32'h33 : 32'h22, 32'h55));
    tbl.push_back(mk(0, 1, 5'd9,  32'h44,       1, 5'd9,  1, 5'd9,
                     BYP ? 32'h44 : 32'h33, BYP ? 32'h44 : 32'h33));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd9,  1, 5'd9,  32'h44, 32'h44));
    // disabled port ignores a matching write
    tbl.push_back(mk(0, 1, 5'd10, 32'hAA,       0, 5'd10, 1, 5'd9,  32'h0,  32'h44));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd10, 1, 5'd9,  32'hAA, 32'h44));
    // reset mid-stream drops the write presented with it
    tbl.push_back(mk(0, 1, 5'd4,  32'h99,       1, 5'd4,  1, 5'd10, BYP ? 32'h99 : 32'h0, 32'hAA));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd4,  1, 5'd10, 32'h99, 32'hAA));
    tbl.push_back(mk(1, 1, 5'd4,  32'h77,       1, 5'd4,  1, 5'd4,  32'h0,  32'h0));
    // first edge after reset accepts writes
    tbl.push_back(mk(0, 1, 5'd1,  32'hCAFEF00D, 1, 5'd4,  1, 5'd10, BYP ? 32'h0 : 32'h0, 32'h0));
    tbl.push_back(mk(0, 0, 5'd0,  32'h0,        1, 5'd1,  1, 5'd4,  32'hCAFEF00D, 32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Random phase against the bench model, starting from a known reset.
    for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
    apply(mk(1, 0, 5'd0, 32'h0, 1, 5'd1, 1, 5'd1, 32'h0, 32'h0), 1000);
    for (int c = 0; c < 300; c++) begin
      vec_t v;
      v.rst   = ($urandom_range(0, 49) == 0);
      v.wreg  = ($urandom_range(0, 2) != 0);
      v.wd    = 5'($urandom_range(0, 31));
      v.wdata = $urandom;
      v.re1   = ($urandom_range(0, 5) != 0);
      v.ra1   = ($urandom_range(0, 3) == 0) ? v.wd : 5'($urandom_range(0, 31));
      v.re2   = ($urandom_range(0, 5) != 0);
      v.ra2   = ($urandom_range(0, 3) == 0) ? v.ra1 : 5'($urandom_range(0, 31));
      v.e1    = model_rd(v, v.re1, v.ra1);
      v.e2    = model_rd(v, v.re2, v.ra2);
      apply(v, 1001 + c);
      if (v.rst) begin
        for (int k = 0; k < 32; k++) mdl[k] = 32'h0;
      end else if (v.wreg && v.wd != 5'd0) begin
        mdl[v.wd] = v.wdata;
      end
    end

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
